// File: rtl/karatsuba_acc.sv
// Accumulates a programmed number of 32-bit products into an ACC_W-bit sum with a sticky carry-out flag.
// Build option KARATSUBA_ACC_SATURATE_EN: clamp to all-ones on carry-out instead of wrapping.
module karatsuba_acc #(
  parameter int ACC_W = 40,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             overflow,
  output logic             busy
);

  // state  | meaning
  // IDLE   | waiting for start; acc_out holds the last result
  // ACCUM  | accepting products, count holds terms remaining
  // DONE   | result presented until out_ready
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] count_q;
  logic [ACC_W-1:0] acc_q;
  logic             ovf_q;
  logic [ACC_W:0]   sum;
  logic             hs;
  logic             launch;

  assign hs     = in_valid && (state_q == S_ACCUM);
  assign launch = start && (state_q == S_IDLE);
  assign sum    = {1'b0, acc_q} + {{(ACC_W + 1 - 32){1'b0}}, prod};

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (len == '0) ? S_DONE : S_ACCUM;
      S_ACCUM: if (hs && count_q == LEN_W'(1)) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (launch) begin
        count_q <= len;
        acc_q   <= '0;
        ovf_q   <= 1'b0;
      end else if (hs) begin
        count_q <= count_q - LEN_W'(1);
        if (sum[ACC_W]) ovf_q <= 1'b1;
`ifdef KARATSUBA_ACC_SATURATE_EN
        // once clamped, any further nonzero add carries again, so the clamp holds
        acc_q <= sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
        acc_q <= sum[ACC_W-1:0];
`endif
      end
    end
  end

  assign in_ready  = (state_q == S_ACCUM);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign acc_out   = acc_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_karatsuba_acc.sv
// Randomised self-checking bench for karatsuba_acc against an arithmetic reference model.
module tb_karatsuba_acc;
  localparam int ACC_W = 34;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      prod = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] acc_out;
  logic             overflow;
  logic             busy;

  int          vec_cnt = 0;
  int          err_cnt = 0;
  int          hs_cnt;
  logic [31:0] prods[$];

  karatsuba_acc #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .prod(prod),
    .out_valid(out_valid), .out_ready(out_ready),
    .acc_out(acc_out), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: plain integer sum of the queued products, with wrap or clamp at 2^ACC_W.
  function automatic void model(output logic [ACC_W-1:0] e_acc, output logic e_ovf);
    longint unsigned s   = 0;
    longint unsigned lim = 64'd1 << ACC_W;
    e_ovf = 1'b0;
    foreach (prods[i]) begin
      s = s + longint'(prods[i]);
      if (s >= lim) begin
        e_ovf = 1'b1;
`ifdef KARATSUBA_ACC_SATURATE_EN
        s = lim - 1;
`else
        s = s - lim;
`endif
      end
    end
    e_acc = s[ACC_W-1:0];
  endfunction

  // Tasks are entered just after a falling edge; they drive, then step to the next falling edge.
  task automatic start_run(input int n);
    start = 1'b1;
    len   = LEN_W'(n);
    @(negedge clk);
    start = 1'b0;
    len   = LEN_W'($urandom);
    vec_cnt++;
    if (busy !== 1'b1) begin err_cnt++; $display("FAIL start_busy: got %b expected 1", busy); end
    vec_cnt++;
    if (n != 0 && in_ready !== 1'b1) begin err_cnt++; $display("FAIL start_in_ready: got %b expected 1", in_ready); end
    else if (n == 0 && out_valid !== 1'b1) begin err_cnt++; $display("FAIL start_zero_len: out_valid got %b expected 1", out_valid); end
  endtask

  task automatic feed(input int gmin, input int gmax, input bit expect_done);
    int gap;
    hs_cnt = 0;
    foreach (prods[i]) begin
      gap = $urandom_range(gmax, gmin);
      repeat (gap) begin
        in_valid = 1'b0;
        prod     = $urandom;
        vec_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
          err_cnt++; $display("FAIL in_ready_bubble: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
        @(negedge clk);
      end
      in_valid = 1'b1;
      prod     = prods[i];
      vec_cnt++;
      if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL in_ready_beat %0d: got %b expected 1", i, in_ready); end
      if (in_ready === 1'b1) hs_cnt++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (expect_done) begin
      vec_cnt++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        err_cnt++; $display("FAIL done_latency: got out_valid=%b in_ready=%b expected 1/0", out_valid, in_ready);
      end
    end
  endtask

  task automatic check_result(input string name);
    logic [ACC_W-1:0] e_acc;
    logic             e_ovf;
    model(e_acc, e_ovf);
    vec_cnt++;
    if (acc_out !== e_acc) begin err_cnt++; $display("FAIL %s acc_out: got %h expected %h", name, acc_out, e_acc); end
    vec_cnt++;
    if (overflow !== e_ovf) begin err_cnt++; $display("FAIL %s overflow: got %b expected %b", name, overflow, e_ovf); end
  endtask

  task automatic release_result();
    logic [ACC_W-1:0] held;
    held      = acc_out;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    vec_cnt++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || acc_out !== held) begin
      err_cnt++;
      $display("FAIL release: got out_valid=%b busy=%b acc_out=%h expected 0/0/%h", out_valid, busy, acc_out, held);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    vec_cnt++;
    if (acc_out !== '0 || overflow !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_state: got acc=%h ovf=%b in_ready=%b out_valid=%b busy=%b expected all 0",
               acc_out, overflow, in_ready, out_valid, busy);
    end
  endtask

  task automatic test_basic();
    prods = {32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001};
    start_run(3);
    feed(0, 0, 1);
    vec_cnt++;
    if (acc_out !== 34'h2FFFA0003) begin err_cnt++; $display("FAIL basic_const: got %h expected 2fffa0003", acc_out); end
    check_result("basic");
    release_result();
  endtask

  task automatic test_bubbles();
    prods = {32'd1, 32'd2, 32'd3, 32'd4};
    start_run(4);
    feed(2, 2, 1);
    vec_cnt++;
    if (hs_cnt != 4) begin err_cnt++; $display("FAIL bubbles_handshakes: got %0d expected 4", hs_cnt); end
    vec_cnt++;
    if (acc_out !== 34'd10) begin err_cnt++; $display("FAIL bubbles_sum: got %0d expected 10", acc_out); end
    release_result();
  endtask

  task automatic test_zero_backpressure();
    logic [ACC_W-1:0] held;
    logic             held_ovf;
    prods = {};
    start_run(0);
    check_result("zero_len");
    release_result();
    prods = {$urandom, $urandom};
    start_run(2);
    feed(0, 1, 1);
    check_result("backpressure");
    held     = acc_out;
    held_ovf = overflow;
    for (int i = 0; i < 3; i++) begin
      start = (i == 1);
      len   = 8'd3;
      @(negedge clk);
      start = 1'b0;
      vec_cnt++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || acc_out !== held || overflow !== held_ovf) begin
        err_cnt++;
        $display("FAIL backpressure_hold: got out_valid=%b in_ready=%b acc=%h ovf=%b expected 1/0/%h/%b",
                 out_valid, in_ready, acc_out, overflow, held, held_ovf);
      end
    end
    release_result();
  endtask

  task automatic test_overflow();
    logic [ACC_W-1:0] e_const;
`ifdef KARATSUBA_ACC_SATURATE_EN
    e_const = 34'h3FFFFFFFF;
`else
    e_const = 34'h0FFF60005;
`endif
    prods = {32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001};
    start_run(5);
    feed(0, 1, 1);
    vec_cnt++;
    if (acc_out !== e_const || overflow !== 1'b1) begin
      err_cnt++; $display("FAIL overflow_const: got acc=%h ovf=%b expected %h/1", acc_out, overflow, e_const);
    end
    check_result("overflow");
    release_result();
  endtask

  task automatic test_reset_mid();
    prods = {32'h0000_1234, 32'h00AB_0000};
    start_run(4);
    feed(0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vec_cnt++;
    if (acc_out !== '0 || in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_mid: got acc=%h in_ready=%b out_valid=%b busy=%b expected 0/0/0/0",
               acc_out, in_ready, out_valid, busy);
    end
    prods = {32'd7};
    start_run(1);
    feed(0, 0, 1);
    vec_cnt++;
    if (acc_out !== 34'd7 || overflow !== 1'b0) begin
      err_cnt++; $display("FAIL reset_mid_rerun: got acc=%h ovf=%b expected 7/0", acc_out, overflow);
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    int n;
    prods = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    start_run(5);
    feed(0, 0, 1);
    check_result("b2b_first");
    release_result();
    n = $urandom_range(4, 1);
    prods = {};
    for (int i = 0; i < n; i++) prods.push_back($urandom_range(32'hFFFF, 0));
    start_run(n);
    feed(0, 0, 1);
    check_result("b2b_second");
    release_result();
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 12; r++) begin
      n = $urandom_range(12, 1);
      prods = {};
      for (int i = 0; i < n; i++) prods.push_back($urandom);
      in_valid = 1'b1;
      prod     = $urandom;
      @(negedge clk);
      in_valid = 1'b0;
      start_run(n);
      feed(0, 2, 1);
      repeat ($urandom_range(3, 0)) @(negedge clk);
      check_result("random");
      release_result();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bubbles();
    test_zero_backpressure();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
